// File: rtl/bus2wb_master_if.sv
// Core-side valid/ready channels plus Wishbone classic signals for bus2wb_master.
// master: the bridge's view (drives Wishbone and the core-side readies/responses).
// slave: the surrounding core and Wishbone slave, the mirror of master.
interface bus2wb_master_if #(
    parameter int addr_width   = 32,
    parameter int data_width   = 32,
    parameter int strobe_width = data_width / 8
);
    logic                    rd_addr_valid;
    logic                    rd_addr_ready;
    logic [addr_width-1:0]   rd_addr;
    logic                    rd_data_valid;
    logic                    rd_data_ready;
    logic [data_width-1:0]   rd_data;
    logic                    wr_req_valid;
    logic                    wr_req_ready;
    logic [addr_width-1:0]   wr_addr;
    logic [data_width-1:0]   wr_data;
    logic [strobe_width-1:0] wr_strobe;
    logic                    wr_resp_valid;
    logic                    wr_resp_ready;
    logic [addr_width-1:0]   wb_adr;
    logic [data_width-1:0]   wb_datwr;
    logic [data_width-1:0]   wb_datrd;
    logic                    wb_we;
    logic                    wb_stb;
    logic                    wb_ack;
    logic                    wb_cyc;
    logic [strobe_width-1:0] wb_sel;

    modport master (
        input  rd_addr_valid, rd_addr, rd_data_ready,
        output rd_addr_ready, rd_data_valid, rd_data,
        input  wr_req_valid, wr_addr, wr_data, wr_strobe, wr_resp_ready,
        output wr_req_ready, wr_resp_valid,
        output wb_adr, wb_datwr, wb_we, wb_stb, wb_cyc, wb_sel,
        input  wb_datrd, wb_ack
    );

    modport slave (
        output rd_addr_valid, rd_addr, rd_data_ready,
        input  rd_addr_ready, rd_data_valid, rd_data,
        output wr_req_valid, wr_addr, wr_data, wr_strobe, wr_resp_ready,
        input  wr_req_ready, wr_resp_valid,
        input  wb_adr, wb_datwr, wb_we, wb_stb, wb_cyc, wb_sel,
        output wb_datrd, wb_ack
    );
endinterface

// File: rtl/bus2wb_master.sv
// Bridges valid/ready read and write channels onto single Wishbone classic transfers, one at a time.
// Latency: accept at T, stb/cyc from T, response valid two edges after accept with a 1-cycle-ack slave.
// Backpressure: readies only in IDLE; a Wishbone cycle waits for ack, a response waits for its ready.
module bus2wb_master #(
    parameter int addr_width   = 32,
    parameter int data_width   = 32,
    parameter int strobe_width = data_width / 8
) (
    input  logic           clock,
    input  logic           reset,
    bus2wb_master_if.master bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_CYC  = 3'd1;
    localparam logic [2:0] WR_CYC  = 3'd2;
    localparam logic [2:0] RD_RESP = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;

    localparam logic GRANT_READ  = 1'b0;
    localparam logic GRANT_WRITE = 1'b1;

    logic [2:0] state;
    logic       last_grant;
    logic       grant_rd;
    logic       grant_wr;

    // Round-robin grant in IDLE; a lone requester always wins, ties go opposite to last_grant.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state == IDLE) begin
            if (bus.rd_addr_valid && (!bus.wr_req_valid || last_grant == GRANT_WRITE)) begin
                grant_rd = 1'b1;
            end else if (bus.wr_req_valid) begin
                grant_wr = 1'b1;
            end
        end
    end

    assign bus.rd_addr_ready = grant_rd;
    assign bus.wr_req_ready  = grant_wr;

    // Transfer sequencer: launch a Wishbone cycle on accept, hold it until ack, then present the response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            last_grant        <= GRANT_WRITE;
            bus.wb_cyc        <= 1'b0;
            bus.wb_stb        <= 1'b0;
            bus.wb_we         <= 1'b0;
            bus.wb_adr        <= '0;
            bus.wb_datwr      <= '0;
            bus.wb_sel        <= '0;
            bus.rd_data       <= '0;
            bus.rd_data_valid <= 1'b0;
            bus.wr_resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        bus.wb_adr <= bus.rd_addr;
                        bus.wb_sel <= {strobe_width{1'b1}};
                        bus.wb_we  <= 1'b0;
                        bus.wb_cyc <= 1'b1;
                        bus.wb_stb <= 1'b1;
                        last_grant <= GRANT_READ;
                        state      <= RD_CYC;
                    end else if (grant_wr) begin
                        bus.wb_adr   <= bus.wr_addr;
                        bus.wb_datwr <= bus.wr_data;
                        bus.wb_sel   <= bus.wr_strobe;
                        bus.wb_we    <= 1'b1;
                        bus.wb_cyc   <= 1'b1;
                        bus.wb_stb   <= 1'b1;
                        last_grant   <= GRANT_WRITE;
                        state        <= WR_CYC;
                    end
                end
                RD_CYC: begin
                    if (bus.wb_ack && bus.wb_stb) begin
                        bus.wb_cyc        <= 1'b0;
                        bus.wb_stb        <= 1'b0;
                        bus.wb_we         <= 1'b0;
                        bus.rd_data       <= bus.wb_datrd;
                        bus.rd_data_valid <= 1'b1;
                        state             <= RD_RESP;
                    end
                end
                WR_CYC: begin
                    if (bus.wb_ack && bus.wb_stb) begin
                        bus.wb_cyc        <= 1'b0;
                        bus.wb_stb        <= 1'b0;
                        bus.wb_we         <= 1'b0;
                        bus.wr_resp_valid <= 1'b1;
                        state             <= WR_RESP;
                    end
                end
                RD_RESP: begin
                    if (bus.rd_data_ready) begin
                        bus.rd_data_valid <= 1'b0;
                        state             <= IDLE;
                    end
                end
                WR_RESP: begin
                    if (bus.wr_resp_ready) begin
                        bus.wr_resp_valid <= 1'b0;
                        state             <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus2wb_master.sv
// Bench for bus2wb_master: directed requests, an SRAM-like Wishbone slave with programmable ack delay,
// and a scoreboard whose monitor pops expected responses whenever the bridge hands one over.
module tb_bus2wb_master;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bus2wb_master_if #(.addr_width(32), .data_width(32)) bus ();

    bus2wb_master #(.addr_width(32), .data_width(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        is_wr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // SRAM-like slave: ack after slave_wait cycles of strobe, data moved on the ack edge.
    logic [31:0] mem [0:63];
    int          slave_wait = 1;
    int          slave_cnt;
    always @(posedge clock) begin
        if (reset) begin
            slave_cnt    <= 0;
            bus.wb_ack   <= 1'b0;
            bus.wb_datrd <= 32'h0;
            mem[8]       <= 32'h11223344;
        end else if (!(bus.wb_cyc && bus.wb_stb) || bus.wb_ack) begin
            slave_cnt  <= 0;
            bus.wb_ack <= 1'b0;
        end else begin
            slave_cnt <= slave_cnt + 1;
            if (slave_cnt + 1 == slave_wait) begin
                bus.wb_ack <= 1'b1;
                if (bus.wb_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.wb_sel[b]) mem[bus.wb_adr[7:2]][8*b +: 8] <= bus.wb_datwr[8*b +: 8];
                    end
                end else begin
                    bus.wb_datrd <= mem[bus.wb_adr[7:2]];
                end
            end
        end
    end

    // Monitor: Wishbone protocol checks, per-transfer bookkeeping, and scoreboard pops on handshakes.
    int          stb_len = 0;
    int          last_stb_len = 0;
    int          ack_cnt = 0;
    logic        prev_stb = 1'b0;
    logic        prev_end = 1'b0;
    logic [68:0] cap;
    logic [3:0]  last_sel = 4'h0;
    logic        last_we = 1'b0;
    exp_t        e;
    always @(negedge clock) begin
        if (reset) begin
            stb_len  = 0;
            prev_stb = 1'b0;
            prev_end = 1'b0;
        end else begin
            if (bus.wb_stb || bus.wb_cyc) check("cyc_stb_together", {bus.wb_cyc, bus.wb_stb}, 2'b11);
            if (prev_end) check("idle_gap", bus.wb_cyc, 1'b0);
            if (bus.wb_stb) begin
                if (!prev_stb) cap = {bus.wb_adr, bus.wb_datwr, bus.wb_sel, bus.wb_we};
                else check("wb_hold_stable", {bus.wb_adr, bus.wb_datwr, bus.wb_sel, bus.wb_we}, cap);
                stb_len++;
                if (bus.wb_ack) begin
                    last_stb_len = stb_len;
                    last_sel     = bus.wb_sel;
                    last_we      = bus.wb_we;
                    ack_cnt++;
                    stb_len      = 0;
                end
            end
            prev_end = bus.wb_stb && bus.wb_ack;
            prev_stb = bus.wb_stb && !bus.wb_ack;
            if (bus.rd_data_valid && bus.rd_data_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rd_resp", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_type_rd", 1'b0, e.is_wr);
                    check("rd_data", bus.rd_data, e.data);
                end
            end
            if (bus.wr_resp_valid && bus.wr_resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr_resp", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_type_wr", 1'b1, e.is_wr);
                end
            end
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        bus.wr_addr      = a;
        bus.wr_data      = d;
        bus.wr_strobe    = s;
        bus.wr_req_valid = 1'b1;
        #1;
        while (!bus.wr_req_ready && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n == 100) begin
            check("wr_accept_timeout", 1'b0, 1'b1);
        end else begin
            exp_q.push_back('{is_wr: 1'b1, data: 32'h0});
            @(posedge clock);
            #1;
        end
        bus.wr_req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        bus.rd_addr       = a;
        bus.rd_addr_valid = 1'b1;
        #1;
        while (!bus.rd_addr_ready && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n == 100) begin
            check("rd_accept_timeout", 1'b0, 1'b1);
        end else begin
            exp_q.push_back('{is_wr: 1'b0, data: d});
            @(posedge clock);
            #1;
        end
        bus.rd_addr_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(posedge clock);
            #1;
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   a0;
        int   n;
        int   k;
        logic rd_ok;
        logic wr_ok;
        logic order [4];
        order = '{1'b0, 1'b1, 1'b0, 1'b1};

        reset             = 1'b1;
        bus.rd_addr_valid = 1'b0;
        bus.rd_addr       = 32'h0;
        bus.rd_data_ready = 1'b1;
        bus.wr_req_valid  = 1'b0;
        bus.wr_addr       = 32'h0;
        bus.wr_data       = 32'h0;
        bus.wr_strobe     = 4'h0;
        bus.wr_resp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_wb_ctrl", {bus.wb_cyc, bus.wb_stb, bus.wb_we}, 3'b000);
        check("rst_wb_adr", bus.wb_adr, 32'h0);
        check("rst_wb_datwr", bus.wb_datwr, 32'h0);
        check("rst_wb_sel", bus.wb_sel, 4'h0);
        check("rst_resp_valid", {bus.rd_data_valid, bus.wr_resp_valid}, 2'b00);
        check("rst_rd_data", bus.rd_data, 32'h0);
        check("rst_readies", {bus.rd_addr_ready, bus.wr_req_ready}, 2'b00);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single write with 1-cycle-ack slave, cycle-exact latency.
        a0 = ack_cnt;
        do_write(32'h10, 32'hDEADBEEF, 4'hF);
        check("wr_cyc_stb_we", {bus.wb_cyc, bus.wb_stb, bus.wb_we}, 3'b111);
        check("wr_adr", bus.wb_adr, 32'h10);
        check("wr_datwr", bus.wb_datwr, 32'hDEADBEEF);
        check("wr_sel", bus.wb_sel, 4'hF);
        check("wr_ready_busy", bus.wr_req_ready, 1'b0);
        @(posedge clock);
        #1;
        check("wr_ack_seen", bus.wb_ack, 1'b1);
        check("wr_resp_not_yet", bus.wr_resp_valid, 1'b0);
        @(posedge clock);
        #1;
        check("wr_resp_after_ack", bus.wr_resp_valid, 1'b1);
        check("wr_cyc_dropped", {bus.wb_cyc, bus.wb_stb, bus.wb_we}, 3'b000);
        drain();
        check("wr_one_ack", ack_cnt - a0, 1);
        check("wr_last_we_sel", {last_we, last_sel}, 5'h1F);

        // Read back with the consumer stalling; data must be held.
        bus.rd_data_ready = 1'b0;
        do_read(32'h10, 32'hDEADBEEF);
        k = 0;
        while (!bus.rd_data_valid && k < 50) begin
            @(posedge clock);
            #1;
            k++;
        end
        check("rd_valid_arrives", bus.rd_data_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("rd_hold_valid", bus.rd_data_valid, 1'b1);
            check("rd_hold_data", bus.rd_data, 32'hDEADBEEF);
        end
        bus.rd_data_ready = 1'b1;
        @(posedge clock);
        #1;
        check("rd_valid_cleared", bus.rd_data_valid, 1'b0);
        drain();

        // Byte-lane write merges into preloaded word.
        do_write(32'h20, 32'h0000AB00, 4'h2);
        drain();
        check("byte_sel", last_sel, 4'h2);
        do_read(32'h20, 32'h1122AB44);
        drain();
        check("rd_sel_all_ones", last_sel, 4'hF);

        // Slow slave: five extra wait cycles, one response only.
        slave_wait = 5;
        a0 = ack_cnt;
        do_write(32'h30, 32'h12345678, 4'hF);
        drain();
        check("slow_stb_len", last_stb_len, 6);
        repeat (5) @(posedge clock);
        #1;
        check("slow_one_ack", ack_cnt - a0, 1);
        check("slow_no_extra_resp", bus.wr_resp_valid, 1'b0);
        slave_wait = 1;
        do_read(32'h30, 32'h12345678);
        drain();

        // Both channels valid continuously from reset: read, write, read, write.
        reset             = 1'b1;
        bus.rd_addr       = 32'h10;
        bus.wr_addr       = 32'h40;
        bus.wr_data       = 32'h00000055;
        bus.wr_strobe     = 4'hF;
        bus.rd_addr_valid = 1'b1;
        bus.wr_req_valid  = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back('{is_wr: order[i], data: order[i] ? 32'h0 : 32'hDEADBEEF});
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        n = 0;
        k = 0;
        while (n < 4 && k < 200) begin
            @(negedge clock);
            rd_ok = bus.rd_addr_valid && bus.rd_addr_ready;
            wr_ok = bus.wr_req_valid && bus.wr_req_ready;
            if (rd_ok || wr_ok) begin
                check("grant_order", {rd_ok, wr_ok}, order[n] ? 2'b01 : 2'b10);
                n++;
            end
            @(posedge clock);
            #1;
            k++;
        end
        check("grant_count", n, 4);
        bus.rd_addr_valid = 1'b0;
        bus.wr_req_valid  = 1'b0;
        drain();

        // Reset while a long Wishbone cycle is in flight.
        slave_wait        = 20;
        bus.rd_addr       = 32'h10;
        bus.rd_addr_valid = 1'b1;
        k = 0;
        while (!bus.wb_stb && k < 20) begin
            @(posedge clock);
            #1;
            k++;
        end
        check("midrst_stb_up", bus.wb_stb, 1'b1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_cyc_stb", {bus.wb_cyc, bus.wb_stb}, 2'b00);
        check("midrst_no_resp", {bus.rd_data_valid, bus.wr_resp_valid}, 2'b00);
        check("midrst_idle_ready", bus.rd_addr_ready, 1'b1);
        bus.rd_addr_valid = 1'b0;
        reset = 1'b0;
        repeat (25) @(posedge clock);
        #1;
        check("midrst_discarded", {bus.rd_data_valid, bus.wr_resp_valid}, 2'b00);
        slave_wait = 1;
        do_read(32'h10, 32'hDEADBEEF);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus2wb_master.md
Name: bus2wb_master

Overview:
- Wishbone classic master bridge that sits directly upstream of the wishbone SRAM slave.
- Converts the core's valid/ready split bus into single Wishbone transfers, one at a time:
  - read address channel in, read data channel out;
  - write request channel in, write response channel out.
- Arbitrates between pending reads and writes and holds each Wishbone cycle until the slave acks.

Parameters:
- addr_width, 32, address width of both the core bus and wb_adr.
- data_width, 32, data width of both buses.
- strobe_width, data_width/8, byte-lane select width (wr_strobe, wb_sel).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- rd_addr_valid  input  1  read request valid.
- rd_addr_ready  output  1  read request accepted when valid&&ready.
- rd_addr  input  addr_width  read byte address.
- rd_data_valid  output  1  read data valid.
- rd_data_ready  input  1  consumer takes read data.
- rd_data  output  data_width  read data.
- wr_req_valid  input  1  write request valid.
- wr_req_ready  output  1  write request accepted when valid&&ready.
- wr_addr  input  addr_width  write byte address.
- wr_data  input  data_width  write data.
- wr_strobe  input  strobe_width  write byte enables.
- wr_resp_valid  output  1  write completed.
- wr_resp_ready  input  1  consumer takes write response.
- wb_adr  output  addr_width  Wishbone address.
- wb_datwr  output  data_width  Wishbone write data.
- wb_datrd  input  data_width  Wishbone read data.
- wb_we  output  1  Wishbone write enable.
- wb_stb  output  1  Wishbone strobe.
- wb_ack  input  1  Wishbone acknowledge.
- wb_cyc  output  1  Wishbone cycle.
- wb_sel  output  strobe_width  Wishbone byte select.

Behaviour:
- All outputs registered except rd_addr_ready/wr_req_ready, which are decoded from state and grant.
- Reset values: wb_cyc=wb_stb=wb_we=0, wb_adr=wb_datwr=wb_sel=0, rd_data_valid=wr_resp_valid=0, rd_data=0, state=IDLE, last_grant=WRITE.
- States: IDLE, RD_CYC, WR_CYC, RD_RESP, WR_RESP.
- IDLE:
  - Grant logic:
    - only rd_addr_valid -> grant read;
    - only wr_req_valid -> grant write;
    - both valid -> grant the type opposite last_grant (round-robin), so read wins first after reset.
  - Ready behaviour: the granted channel's ready is high combinationally; the other ready is 0; both readies are 0 outside IDLE.
  - On accept:
    - register address, data and strobe (read: wb_sel all ones, wb_datwr unchanged);
    - set wb_cyc=wb_stb=1 and wb_we (1 for write);
    - update last_grant;
    - go to RD_CYC/WR_CYC.
- RD_CYC/WR_CYC:
  - Hold wb_cyc, wb_stb, wb_adr, wb_datwr, wb_sel, wb_we stable until wb_ack=1 is sampled.
  - On ack:
    - clear wb_cyc/wb_stb/wb_we on the same edge;
    - read only: capture wb_datrd into rd_data and set rd_data_valid;
    - write only: set wr_resp_valid;
    - go to RD_RESP/WR_RESP.
  - No timeout: the cycle waits indefinitely for ack.
- RD_RESP/WR_RESP: hold valid and rd_data until the matching ready is 1; then clear valid and return to IDLE. No new request is accepted in the same cycle as the response handshake.
- wb_ack sampled while wb_stb=0 is ignored.
- Latency with a 1-cycle-ack slave:
  - request accepted at edge T;
  - stb/cyc high after T;
  - ack high after T+1;
  - response valid after T+2;
  - the next accept is at the earliest at edge T+4 when the response is taken immediately.
- Back-to-back Wishbone cycles always have at least one idle cycle with wb_cyc=0.
- The bridge never issues wb_stb without wb_cyc; wb_cyc and wb_stb are asserted and deasserted together.
- Reset mid-operation: on the reset edge wb_cyc/wb_stb drop, any pending response is discarded, and state returns to IDLE.
- Addresses and data pass through unmodified; no alignment checks.

Test Plan:
- Write A=0x10, D=0xDEADBEEF, strobe=0xF, against the SRAM slave -> wb_we=1, wb_sel=0xF for exactly 1 stb cycle; wr_resp_valid one cycle after ack.
- Read A=0x10 after that write -> rd_data=0xDEADBEEF; rd_data_valid held until rd_data_ready.
- rd_addr_valid and wr_req_valid asserted together, continuously, starting from reset -> grant order read, write, read, write.
- Slave ack delayed 5 cycles -> wb_cyc/wb_stb/wb_adr held stable for 6 cycles; only one response is produced.
- Byte write strobe=0x2, D=0x0000AB00 to A=0x20 preloaded with 0x11223344, then read A=0x20 -> rd_data=0x1122AB44.
- Reset asserted while wb_stb=1 -> next cycle wb_cyc=wb_stb=0, no response valid, IDLE ready again.
